// File: rtl/olink_ctrl_pkg.sv
// Shared state encoding, timing defaults and counter-width helpers for the
// optical-link bring-up sequencer.
package olink_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_QPLL_RST   = 4'd1,
        ST_QPLL_WAIT  = 4'd2,
        ST_MMCM_RST   = 4'd3,
        ST_MMCM_WAIT  = 4'd4,
        ST_GT_RST     = 4'd5,
        ST_ALIGN_WAIT = 4'd6,
        ST_UP         = 4'd7,
        ST_FAIL       = 4'd8,
        ST_BACKOFF    = 4'd9,
        ST_HALT       = 4'd10
    } state_t;

    localparam int DEF_NLINKS         = 2;
    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT   = 125000;
    localparam int DEF_ALIGN_TIMEOUT  = 250000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_BACKOFF_CYCLES = 62500;
    localparam int DEF_MAX_RETRY      = 8;

    // Bits needed to hold max_val-1 (a counter that loads N-1 and counts to 0).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return cnt_width(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous status inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/olink_bringup_ctrl.sv
// Bring-up sequencer for the shared QPLL, link-clock MMCM and GTX channels:
// reset/lock/align sequencing, link monitoring, retry with backoff and halt.
module olink_bringup_ctrl
    import olink_ctrl_pkg::*;
#(
    parameter int NLINKS         = DEF_NLINKS,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int ALIGN_TIMEOUT  = DEF_ALIGN_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic              sysClk125,
    input  logic              sysClk125RstN,
    input  logic              enable,
    input  logic              restart,
    input  logic              clearErr,
    input  logic              qpllLock,
    input  logic              qpllRefClkLost,
    input  logic              mmcmLocked,
    input  logic [NLINKS-1:0] rxValid,
    output logic              qpllReset,
    output logic              mmcmReset,
    output logic [NLINKS-1:0] gtReset,
    output logic              linkUp,
    output logic [3:0]        state,
    output logic [7:0]        retryCount,
    output logic              errSticky,
    output logic [15:0]       dropCount
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, ALIGN_TIMEOUT, BACKOFF_CYCLES);
    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam logic [TW-1:0] RST_LOAD     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] ALIGN_LOAD   = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [TW-1:0] BACKOFF_LOAD = TW'(BACKOFF_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRY);

    logic [2:0]        lock_s;
    logic              qpll_lock_s, refclk_lost_s, mmcm_lock_s;
    logic [NLINKS-1:0] rx_valid_s;
    logic              all_valid;

    sync_2ff #(.WIDTH(3)) u_sync_lock (
        .clk   (sysClk125),
        .rst_n (sysClk125RstN),
        .d_i   ({qpllRefClkLost, mmcmLocked, qpllLock}),
        .q_o   (lock_s)
    );

    sync_2ff #(.WIDTH(NLINKS)) u_sync_rx (
        .clk   (sysClk125),
        .rst_n (sysClk125RstN),
        .d_i   (rxValid),
        .q_o   (rx_valid_s)
    );

    assign {refclk_lost_s, mmcm_lock_s, qpll_lock_s} = lock_s;
    assign all_valid = &rx_valid_s;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     stable_q, stable_d;
    logic [7:0]        retry_q, retry_d;
    logic [15:0]       drop_q, drop_d;
    logic              err_q, err_d;
    logic              qpll_rst_q, qpll_rst_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic [NLINKS-1:0] gt_rst_q, gt_rst_d;
    logic              link_up_q, link_up_d;
    logic              timer_done, restart_hit, enter;

    assign timer_done = (timer_q == '0);

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path infers a latch.
        state_d     = state_q;
        timer_d     = timer_done ? timer_q : timer_q - 1'b1;
        stable_d    = '0;
        retry_d     = retry_q;
        drop_d      = drop_q;
        restart_hit = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (restart && (state_q != ST_IDLE)) begin
            state_d     = ST_QPLL_RST;
            retry_d     = '0;
            restart_hit = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_QPLL_RST;
                ST_QPLL_RST:  if (timer_done) state_d = ST_QPLL_WAIT;
                ST_QPLL_WAIT: begin
                    if (qpll_lock_s && !refclk_lost_s) state_d = ST_MMCM_RST;
                    else if (timer_done)               state_d = ST_FAIL;
                end
                ST_MMCM_RST:  if (timer_done) state_d = ST_MMCM_WAIT;
                ST_MMCM_WAIT: begin
                    if (mmcm_lock_s)     state_d = ST_GT_RST;
                    else if (timer_done) state_d = ST_FAIL;
                end
                ST_GT_RST:    if (timer_done) state_d = ST_ALIGN_WAIT;
                ST_ALIGN_WAIT: begin
                    // A stable run that completes on the timeout cycle still counts as success.
                    if (all_valid && (stable_q == STABLE_LAST)) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else if (timer_done) begin
                        state_d = ST_FAIL;
                    end else if (all_valid) begin
                        stable_d = stable_q + 1'b1;
                    end
                end
                ST_UP: begin
                    if (!qpll_lock_s || refclk_lost_s || !mmcm_lock_s) state_d = ST_FAIL;
                    else if (!all_valid)                                state_d = ST_GT_RST;
                    if ((state_d != ST_UP) && (drop_q != 16'hFFFF)) drop_d = drop_q + 1'b1;
                end
                ST_FAIL: begin
                    retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 1'b1;
                    state_d = (retry_d >= RETRY_LIMIT) ? ST_HALT : ST_BACKOFF;
                end
                ST_BACKOFF:   if (timer_done) state_d = ST_QPLL_RST;
                ST_HALT:      state_d = ST_HALT;
                default:      state_d = ST_IDLE;
            endcase
        end

        enter = (state_d != state_q) || restart_hit;
        if (enter) begin
            stable_d = '0;
            case (state_d)
                ST_QPLL_RST, ST_MMCM_RST, ST_GT_RST: timer_d = RST_LOAD;
                ST_QPLL_WAIT, ST_MMCM_WAIT:          timer_d = LOCK_LOAD;
                ST_ALIGN_WAIT:                       timer_d = ALIGN_LOAD;
                ST_BACKOFF:                          timer_d = BACKOFF_LOAD;
                default:                             timer_d = '0;
            endcase
        end

        // Outputs are decoded from the next state so the registered copies move with state_q.
        qpll_rst_d = !(state_d inside {ST_QPLL_WAIT, ST_MMCM_RST, ST_MMCM_WAIT,
                                       ST_GT_RST, ST_ALIGN_WAIT, ST_UP});
        mmcm_rst_d = !(state_d inside {ST_MMCM_WAIT, ST_GT_RST, ST_ALIGN_WAIT, ST_UP});
        gt_rst_d   = (state_d inside {ST_ALIGN_WAIT, ST_UP}) ? '0 : '1;
        link_up_d  = (state_d == ST_UP);

        if ((state_d == ST_HALT) && (state_q != ST_HALT)) err_d = 1'b1;
        else if (clearErr)                                err_d = 1'b0;
        else                                              err_d = err_q;
    end

    always_ff @(posedge sysClk125 or negedge sysClk125RstN) begin
        if (!sysClk125RstN) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            stable_q   <= '0;
            retry_q    <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
            qpll_rst_q <= 1'b1;
            mmcm_rst_q <= 1'b1;
            gt_rst_q   <= '1;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stable_q   <= stable_d;
            retry_q    <= retry_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            qpll_rst_q <= qpll_rst_d;
            mmcm_rst_q <= mmcm_rst_d;
            gt_rst_q   <= gt_rst_d;
            link_up_q  <= link_up_d;
        end
    end

    assign state      = state_q;
    assign qpllReset  = qpll_rst_q;
    assign mmcmReset  = mmcm_rst_q;
    assign gtReset    = gt_rst_q;
    assign linkUp     = link_up_q;
    assign retryCount = retry_q;
    assign errSticky  = err_q;
    assign dropCount  = drop_q;

endmodule

// File: tb/tb_olink_bringup_ctrl.sv
// Directed bench for olink_bringup_ctrl: table-driven nominal bring-up plus
// hand-written sequences for drops, retries, priority and async reset.
module tb_olink_bringup_ctrl;

    localparam int NV = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, restart, clear_err;
    logic        qpll_lock, refclk_lost, mmcm_locked;
    logic [1:0]  rx_valid;
    logic        qpll_reset, mmcm_reset, link_up, err_sticky;
    logic [1:0]  gt_reset;
    logic [3:0]  state;
    logic [7:0]  retry_count;
    logic [15:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       en;
        logic       lock;
        logic       mmcm;
        logic [1:0] rxv;
        int         n;
        logic [3:0] st;
        logic       qr;
        logic       mr;
        logic [1:0] gr;
        logic       up;
    } vec_t;

    vec_t vecs [NV];

    olink_bringup_ctrl #(
        .NLINKS         (2),
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (20),
        .ALIGN_TIMEOUT  (40),
        .STABLE_CYCLES  (8),
        .BACKOFF_CYCLES (10),
        .MAX_RETRY      (3)
    ) dut (
        .sysClk125      (clk),
        .sysClk125RstN  (rst_n),
        .enable         (enable),
        .restart        (restart),
        .clearErr       (clear_err),
        .qpllLock       (qpll_lock),
        .qpllRefClkLost (refclk_lost),
        .mmcmLocked     (mmcm_locked),
        .rxValid        (rx_valid),
        .qpllReset      (qpll_reset),
        .mmcmReset      (mmcm_reset),
        .gtReset        (gt_reset),
        .linkUp         (link_up),
        .state          (state),
        .retryCount     (retry_count),
        .errSticky      (err_sticky),
        .dropCount      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, state, s);
    endtask

    // Called on the first sample in state s; leaves the bench on the first sample after it.
    task automatic measure(input logic [3:0] s, input int exp_len, input string name);
        int n = 0;
        while (state === s && n < exp_len + 5) begin
            tick();
            n++;
        end
        check(name, n, exp_len);
    endtask

    task automatic check_resets(input string name, input logic q, input logic m, input logic [1:0] g);
        check({name, ".qpllReset"}, qpll_reset, q);
        check({name, ".mmcmReset"}, mmcm_reset, m);
        check({name, ".gtReset"},   gt_reset,   g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; restart = 1'b0; clear_err = 1'b0;
        qpll_lock = 1'b0; refclk_lost = 1'b0; mmcm_locked = 1'b0; rx_valid = 2'b11;

        //         en    lock  mmcm  rxv    n  st     qr    mr    gr     up
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1, 4'd1, 1'b1, 1'b1, 2'b11, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b11, 3, 4'd1, 1'b1, 1'b1, 2'b11, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1, 4'd2, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b11, 4, 4'd2, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b11, 2, 4'd2, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1, 4'd3, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b11, 3, 4'd3, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 4'd4, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 4'd5, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'b11, 3, 4'd5, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 4'd6, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'b11, 7, 4'd6, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 2'b11, 1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b1};

        // Reset values
        #12;
        check("rst.state", state, 4'd0);
        check_resets("rst", 1'b1, 1'b1, 2'b11);
        check("rst.linkUp", link_up, 1'b0);
        check("rst.retry", retry_count, 8'd0);
        check("rst.err", err_sticky, 1'b0);
        check("rst.drop", drop_count, 16'd0);
        #10 rst_n = 1'b1;
        tick();
        tick();
        check("idle.hold", state, 4'd0);

        // Nominal bring-up
        for (int i = 0; i < NV; i++) begin
            enable      = vecs[i].en;
            qpll_lock   = vecs[i].lock;
            mmcm_locked = vecs[i].mmcm;
            rx_valid    = vecs[i].rxv;
            repeat (vecs[i].n) tick();
            check($sformatf("nom%0d.state", i), state, vecs[i].st);
            check($sformatf("nom%0d.qpllReset", i), qpll_reset, vecs[i].qr);
            check($sformatf("nom%0d.mmcmReset", i), mmcm_reset, vecs[i].mr);
            check($sformatf("nom%0d.gtReset", i), gt_reset, vecs[i].gr);
            check($sformatf("nom%0d.linkUp", i), link_up, vecs[i].up);
        end
        check("nom.retry", retry_count, 8'd0);
        check("nom.drop", drop_count, 16'd0);

        // rxValid drop in UP: linkUp falls with the state change
        rx_valid = 2'b10;
        begin
            int n = 0;
            while (state === 4'd7 && n < 10) begin
                check("drop.linkUp_in_up", link_up, 1'b1);
                tick();
                n++;
            end
        end
        check("drop.state", state, 4'd5);
        check("drop.linkUp", link_up, 1'b0);
        check("drop.count", drop_count, 16'd1);
        check_resets("drop", 1'b0, 1'b0, 2'b11);

        // Realign, then lose QPLL lock in UP
        rx_valid = 2'b11;
        wait_state(4'd7, 40, "realign.up");
        qpll_lock = 1'b0;
        wait_state(4'd8, 10, "lockloss.fail");
        check("lockloss.linkUp", link_up, 1'b0);
        check("lockloss.drop", drop_count, 16'd2);
        check("lockloss.retry", retry_count, 8'd0);
        check_resets("fail", 1'b1, 1'b1, 2'b11);
        tick();
        check("retry1.state", state, 4'd9);
        check("retry1.count", retry_count, 8'd1);

        // QPLL never locks: backoff, retry, timeout until HALT
        measure(4'd9, 10, "backoff1.len");
        check("retry1.qrst", state, 4'd1);
        measure(4'd1, 4, "qrst1.len");
        check("retry1.qwait", state, 4'd2);
        measure(4'd2, 20, "qwait1.len");
        check("timeout1.state", state, 4'd8);
        tick();
        check("retry2.state", state, 4'd9);
        check("retry2.count", retry_count, 8'd2);
        measure(4'd9, 10, "backoff2.len");
        measure(4'd1, 4, "qrst2.len");
        measure(4'd2, 20, "qwait2.len");
        check("timeout2.state", state, 4'd8);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("halt.state", state, 4'd10);
        check("halt.retry", retry_count, 8'd3);
        check("halt.err_set_wins", err_sticky, 1'b1);
        check("halt.linkUp", link_up, 1'b0);
        check_resets("halt", 1'b1, 1'b1, 2'b11);
        repeat (3) tick();
        check("halt.stay", state, 4'd10);

        // Restart out of HALT, then clear the sticky error
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart.state", state, 4'd1);
        check("restart.retry", retry_count, 8'd0);
        check("restart.err_kept", err_sticky, 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clearErr.err", err_sticky, 1'b0);

        // enable=0 beats a coincident restart in MMCM_WAIT
        qpll_lock   = 1'b1;
        mmcm_locked = 1'b0;
        wait_state(4'd4, 40, "prio.mmcm_wait");
        restart = 1'b1;
        enable  = 1'b0;
        tick();
        restart = 1'b0;
        check("prio.state", state, 4'd0);
        check("prio.retry", retry_count, 8'd0);
        check_resets("prio", 1'b1, 1'b1, 2'b11);
        tick();
        check("prio.idle_hold", state, 4'd0);

        // rxValid[1] glitch at stable count 6
        enable      = 1'b1;
        mmcm_locked = 1'b1;
        rx_valid    = 2'b11;
        wait_state(4'd6, 60, "glitch.align");
        repeat (4) tick();
        rx_valid = 2'b01;
        tick();
        rx_valid = 2'b11;
        repeat (9) tick();
        check("glitch.still_align", state, 4'd6);
        tick();
        check("glitch.up", state, 4'd7);
        check("glitch.linkUp", link_up, 1'b1);
        check("glitch.retry", retry_count, 8'd0);

        // Async reset mid-ALIGN_WAIT, off the clock edge
        rx_valid = 2'b10;
        wait_state(4'd6, 20, "areset.align");
        check("areset.drop_before", drop_count, 16'd3);
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("areset.state", state, 4'd0);
        check_resets("areset", 1'b1, 1'b1, 2'b11);
        check("areset.linkUp", link_up, 1'b0);
        check("areset.retry", retry_count, 8'd0);
        check("areset.err", err_sticky, 1'b0);
        check("areset.drop", drop_count, 16'd0);
        #2 rst_n = 1'b1;
        tick();
        check("areset.restart_state", state, 4'd1);
        check("areset.restart_qpllReset", qpll_reset, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
